aes_axil_regbank: RTL
=====================

AES_AXIL_REGBANK -- requirements
Module: aes_axil_regbank

Interface
REQ-001 Parameter DATA_WIDTH, 32, AXI4-Lite data width; legal values 32 or 64.
REQ-002 Parameter NUM_REGS, 8, total register count; power of 2, 4..64.
REQ-003 Parameter NUM_RO, 2, count of read-only status registers at the top indices (NUM_REGS-NUM_RO .. NUM_REGS-1); 0..NUM_REGS-1.
REQ-004 Parameter ADDR_WIDTH, 6, byte-address width; SHALL be at least log2(NUM_REGS*DATA_WIDTH/8).
REQ-005 ACLK  in  1  single clock; all logic rising-edge.
REQ-006 ARESETN  in  1  asynchronous, active-low reset.
REQ-007 AWADDR in ADDR_WIDTH; AWPROT in 3 (ignored); AWVALID in 1; AWREADY out 1: write-address channel.
REQ-008 WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8; WVALID in 1; WREADY out 1: write-data channel.
REQ-009 BRESP out 2; BVALID out 1; BREADY in 1: write-response channel.
REQ-010 ARADDR in ADDR_WIDTH; ARPROT in 3 (ignored); ARVALID in 1; ARREADY out 1: read-address channel.
REQ-011 RDATA out DATA_WIDTH; RRESP out 2; RVALID out 1; RREADY in 1: read-data channel.
REQ-012 ctrl_o  out  (NUM_REGS-NUM_RO)*DATA_WIDTH  flattened read/write registers, register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 status_i  in  NUM_RO*DATA_WIDTH  flattened status values for the read-only registers, same packing.
REQ-014 wr_pulse_o  out  NUM_REGS-NUM_RO  one-cycle strobe per RW register on successful write.

Function
REQ-015 Register index SHALL be byte address bits [ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-016 Write FSM states SHALL be W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP.
REQ-017 AWREADY SHALL be 1 in W_IDLE and W_DATA only; WREADY SHALL be 1 in W_IDLE and W_ADDR only.
REQ-018 W_IDLE: AW-only handshake -> W_ADDR; W-only -> W_DATA; both same edge -> W_RESP; W_ADDR/W_DATA -> W_RESP on the missing handshake.
REQ-019 On the edge entering W_RESP the write SHALL commit: each byte lane with WSTRB=1 updated, others unchanged.
REQ-020 BVALID SHALL be 1 throughout W_RESP with stable BRESP; W_RESP -> W_IDLE on BVALID&BREADY.
REQ-021 BRESP SHALL be OKAY (00) for an RW index, SLVERR (10) for index >= NUM_REGS or a read-only index; SLVERR writes change no state.
REQ-022 wr_pulse_o[k] SHALL be 1 for exactly the first cycle of W_RESP when the commit hit RW register k with OKAY, regardless of WSTRB value.
REQ-023 Read FSM states SHALL be R_IDLE (ARREADY=1) and R_DATA (RVALID=1); R_IDLE -> R_DATA on AR handshake, R_DATA -> R_IDLE on RVALID&RREADY.
REQ-024 RDATA/RRESP SHALL be registered at the AR handshake edge and held stable throughout R_DATA.
REQ-025 Read of RW index returns register contents, RO index returns status_i slice sampled at that edge, both OKAY; index >= NUM_REGS returns RDATA=0, RRESP=SLVERR.
REQ-026 Read and write FSMs SHALL run independently; an AR handshake on the same edge as a commit to the same register SHALL return the pre-write value.
REQ-027 Latency: AW+W handshake to BVALID = 1 cycle; AR handshake to RVALID = 1 cycle; back-to-back transactions sustain one write per 2 cycles and one read per 2 cycles.

Reset
REQ-028 While ARESETN=0: all ctrl_o registers 0, wr_pulse_o 0, BVALID 0, RVALID 0, BRESP 00, RRESP 00, RDATA 0, AWREADY/WREADY/ARREADY 0, FSMs in W_IDLE/R_IDLE.
REQ-029 Reset assertion mid-transaction SHALL abort it immediately; no partial write SHALL persist; after release readies return high in idle states.

Verification (defaults: DATA_WIDTH 32, NUM_REGS 8, NUM_RO 2, ADDR_WIDTH 6)
REQ-030 AW 0x04 and W 0xDEADBEEF/WSTRB 0xF same cycle -> BVALID next cycle, BRESP 00, ctrl_o[63:32]=0xDEADBEEF, wr_pulse_o=0b000010 for one cycle; read 0x04 -> 0xDEADBEEF, OKAY.
REQ-031 W 0x11223344 issued 3 cycles before AW 0x00 -> WREADY drops after W handshake, commit on AW edge; then WSTRB 0x2 with 0xAAAAAAAA -> register 0 reads 0x1122AA44.
REQ-032 status_i register 6 = 0x0000CAFE; read 0x18 -> 0x0000CAFE OKAY; write 0x12345678 to 0x18 -> BRESP 10, read still 0x0000CAFE, wr_pulse_o stays 0.
REQ-033 Read 0x24 -> RDATA 0, RRESP 10; write 0x3C -> BRESP 10, no ctrl_o change.
REQ-034 BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RDATA stable all 5 cycles, no further AW/W/AR accepted until response taken.
REQ-035 ARESETN pulled low in W_ADDR after writing 0x55 to register 1 -> ctrl_o all 0, BVALID 0; after release, W-only handshake alone does not commit (state W_DATA).

Source files
------------

// File: rtl/aes_axil_regbank_if.sv
// AXI4-Lite slave bus bundle for the AES register bank.
interface aes_axil_regbank_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );
endinterface

// File: rtl/aes_axil_regbank.sv
// AXI4-Lite register bank: low indices are RW control registers, top NUM_RO
// indices read back live status; independent write and read FSMs.
module aes_axil_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned NUM_RO     = 2,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                                        ACLK,
  input  logic                                        ARESETN,
  aes_axil_regbank_if.slave                           s_axil,
  output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0]     ctrl_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS-NUM_RO-1:0]                  wr_pulse_o
);
  localparam int unsigned NUM_RW = NUM_REGS - NUM_RO;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}                 rstate_t;

  wstate_t               wstate;
  rstate_t               rstate;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit_en, c_ok;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic [IDX_W-1:0]      c_idx, r_idx;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_val;

  assign aw_hs = s_axil.AWVALID & s_axil.AWREADY;
  assign w_hs  = s_axil.WVALID  & s_axil.WREADY;
  assign ar_hs = s_axil.ARVALID & s_axil.ARREADY;

  // Select the commit source: live channel or the half captured earlier.
  always_comb begin
    commit_en = 1'b0;
    c_addr    = s_axil.AWADDR;
    c_data    = s_axil.WDATA;
    c_strb    = s_axil.WSTRB;
    case (wstate)
      W_IDLE: commit_en = aw_hs & w_hs;
      W_ADDR: begin
        commit_en = w_hs;
        c_addr    = awaddr_q;
      end
      W_DATA: begin
        commit_en = aw_hs;
        c_data    = wdata_q;
        c_strb    = wstrb_q;
      end
      default: commit_en = 1'b0;
    endcase
  end

  assign c_idx = c_addr[ADDR_WIDTH-1:LSB];
  assign c_ok  = 32'(c_idx) < NUM_RW;

  // Write channel FSM.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate         <= W_IDLE;
      s_axil.AWREADY <= 1'b0;
      s_axil.WREADY  <= 1'b0;
      s_axil.BVALID  <= 1'b0;
      s_axil.BRESP   <= 2'b00;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
    end else if (commit_en) begin
      wstate         <= W_RESP;
      s_axil.AWREADY <= 1'b0;
      s_axil.WREADY  <= 1'b0;
      s_axil.BVALID  <= 1'b1;
      s_axil.BRESP   <= c_ok ? 2'b00 : 2'b10;
    end else begin
      case (wstate)
        W_IDLE: begin
          s_axil.AWREADY <= 1'b1;
          s_axil.WREADY  <= 1'b1;
          if (aw_hs) begin
            awaddr_q       <= s_axil.AWADDR;
            wstate         <= W_ADDR;
            s_axil.AWREADY <= 1'b0;
          end else if (w_hs) begin
            wdata_q       <= s_axil.WDATA;
            wstrb_q       <= s_axil.WSTRB;
            wstate        <= W_DATA;
            s_axil.WREADY <= 1'b0;
          end
        end
        W_RESP: begin
          if (s_axil.BREADY) begin
            wstate         <= W_IDLE;
            s_axil.BVALID  <= 1'b0;
            s_axil.AWREADY <= 1'b1;
            s_axil.WREADY  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RW register storage and one-cycle write strobes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_o     <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit_en && c_ok) begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (c_idx == IDX_W'(k)) begin
            wr_pulse_o[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (c_strb[b]) ctrl_o[k*DATA_WIDTH + b*8 +: 8] <= c_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  assign r_idx = s_axil.ARADDR[ADDR_WIDTH-1:LSB];
  assign rd_ok = 32'(r_idx) < NUM_REGS;

  // Read mux over RW storage and status inputs; out-of-range reads as zero.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (r_idx == IDX_W'(k)) rd_val = ctrl_o[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (r_idx == IDX_W'(NUM_RW + k)) rd_val = status_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read channel FSM.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate         <= R_IDLE;
      s_axil.ARREADY <= 1'b0;
      s_axil.RVALID  <= 1'b0;
      s_axil.RDATA   <= '0;
      s_axil.RRESP   <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          s_axil.ARREADY <= 1'b1;
          if (ar_hs) begin
            rstate         <= R_DATA;
            s_axil.ARREADY <= 1'b0;
            s_axil.RVALID  <= 1'b1;
            s_axil.RDATA   <= rd_val;
            s_axil.RRESP   <= rd_ok ? 2'b00 : 2'b10;
          end
        end
        R_DATA: begin
          if (s_axil.RREADY) begin
            rstate         <= R_IDLE;
            s_axil.RVALID  <= 1'b0;
            s_axil.ARREADY <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axil.AWPROT, s_axil.ARPROT, s_axil.AWADDR[LSB-1:0],
                       s_axil.ARADDR[LSB-1:0], awaddr_q[LSB-1:0]};
endmodule
